datapath_seq_core: RTL and testbench
====================================

# datapath_seq_core

Parametrised successor to the single-bus CPU datapath. It bundles the register file, HI/LO, Y, Z, MAR/MDR and ALU with an internal micro-step sequencer. The sequencer executes one register-transfer command per valid/ready handshake, so a control unit or bench issues whole operations instead of driving individual enables. It connects to external RAM through a request/acknowledge memory port with unbounded wait states and a timeout.

## Interface
- WIDTH, 32, datapath/register width (≥8, power of 2)
- NREGS, 16, general registers (power of 2, 2..32); RW = $clog2(NREGS)
- AW, 9, memory address width (≤ WIDTH)
- TIMEOUT, 64, max cycles waiting for mem_ack before abort (≥1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  4  opcode, see Operation
- cmd_ra, cmd_rb, cmd_rc  in  RW  destination / source A / source B
- cmd_imm  in  WIDTH  immediate (ADDI, LD, ST)
- done  out  1  one-cycle pulse, command retired
- err  out  1  valid with done; illegal opcode or memory timeout
- mem_addr  out  AW  MAR[AW-1:0]
- mem_wdata  out  WIDTH  MDR
- mem_re, mem_we  out  1  memory read/write request
- mem_rdata  in  WIDTH  read data, sampled with mem_ack
- mem_ack  in  1  request complete
- hi_out, lo_out  out  WIDTH  HI, LO contents
- dbg_sel  in  RW;  dbg_data  out  WIDTH  combinational register-file read

## Operation
- Opcodes:
  - 0 ADD ra=rb+rc; 1 SUB ra=rb−rc; 2 AND; 3 OR
  - 4 SHR (logical), 5 SHL: shift rb by rc[$clog2(WIDTH)-1:0]
  - 6 ADDI ra=rb'+imm
  - 7 MUL: signed {HI,LO}=rb*rc; ra not written
  - 8 LD ra=mem[rb'+imm]; 9 ST mem[rb'+imm]=ra
  - 10 MFHI ra=HI; 11 MFLO ra=LO; 12 NEG ra=−rb; 13 NOT ra=~rb
  - 14–15 illegal
- rb' = 0 when cmd_rb==0 (base-address rule for ADDI/LD/ST only). Everywhere else R0 is an ordinary register.
- Command fields are latched at acceptance (cmd_valid & cmd_ready). Arithmetic wraps modulo 2^WIDTH. MUL product is 2·WIDTH bits.
- FSM states: IDLE, TY, TZ, TWB, TMAR, TMEM, TLD.
  - IDLE: on accept, go to TY. An illegal opcode goes straight back to IDLE with done=1, err=1 and no state change.
  - TY: Y ← operand A (rb, rb', HI, or LO). Go to TZ.
  - TZ: Z ← ALU(Y, operand B). Operand B is rc, imm, or unused. Go to TWB; LD/ST go to TMAR.
  - TWB: ra ← Zlo, or HI/LO ← Zhi/Zlo for MUL. Go to IDLE with done=1.
  - TMAR: MAR ← Zlo; for ST, MDR ← ra. Go to TMEM.
  - TMEM: mem_re (LD) or mem_we (ST) held high.
    - On mem_ack: ST goes to IDLE with done=1. LD captures MDR ← mem_rdata and goes to TLD.
    - If TIMEOUT cycles pass in TMEM without ack: go to IDLE with done=1, err=1. No register is written.
  - TLD: ra ← MDR. Go to IDLE with done=1.
- mem_ack is ignored outside TMEM. cmd_valid is ignored when not IDLE.

## Timing
- Reset: all registers, HI, LO, Y, Z, MAR, MDR = 0; state=IDLE. Outputs: cmd_ready=1, done=0, err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- clr wins over everything. A clr asserted in any state aborts the command: the request deasserts in the cycle after the clr edge, and no writeback or done occurs.
- Accept edge = E0. ALU, ADDI, MUL and MF* commands write back at E3; done is high in the cycle after E3. cmd_ready is high in that same cycle, so a new command can be accepted at E4. Throughput is 1 command per 4 cycles.
- Memory commands: TMEM is entered after E3, and the request is visible in the cycle after E3.
  - An ack sampled at edge E3+1+k (k wait cycles) completes ST at that edge.
  - LD writes back one edge later.
  - With k=0, LD done follows E5 and ST done follows E4.
- Timeout fires at the edge after TIMEOUT request cycles.
- done and err are registered and high for exactly one cycle.
- dbg_data, hi_out and lo_out reflect register contents after each edge.

## Test plan
- Reset: pulse clr mid-run → all registers read 0 on dbg, cmd_ready=1, mem_re=mem_we=0, done=0.
- ALU chain: ADDI R1,R0,5; ADDI R2,R0,−3; SUB R3,R1,R2; SHL R4,R1,R1 → R3=8, R4=0xA0. Each done is 4 cycles after its accept.
- MUL R1=0xFFFFFFFE, R2=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA, R1–R15 unchanged. MFLO R5 → R5=0xFFFFFFFA.
- Memory: ST R1 to R0+0x10 with ack 2 cycles late → mem_addr=0x10, mem_wdata=R1, mem_we high 3 cycles. LD R6 from 0x10 with mem_rdata=0x1234 → R6=0x1234.
- Timeout (TIMEOUT=4): LD with no ack → mem_re high 4 cycles, done=1 with err=1, R6 unchanged. Opcode 15 → immediate done with err=1.
- clr asserted during TMEM of a ST → mem_we drops the next cycle, no done pulse, registers 0, a new command is accepted right after clr is released.

Source files
------------

// File: rtl/datapath_seq_core_if.sv
// Command handshake and external memory port of datapath_seq_core.
// The core connects through the slave modport; the issuer/RAM side uses master.
interface datapath_seq_core_if #(
   parameter int WIDTH = 32,
   parameter int RW    = 4,
   parameter int AW    = 9
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_op;
   logic [RW-1:0]    cmd_ra;
   logic [RW-1:0]    cmd_rb;
   logic [RW-1:0]    cmd_rc;
   logic [WIDTH-1:0] cmd_imm;
   logic             done;
   logic             err;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_re;
   logic             mem_we;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;

   modport master (
      output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_imm, mem_rdata, mem_ack,
      input  cmd_ready, done, err, mem_addr, mem_wdata, mem_re, mem_we
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_imm, mem_rdata, mem_ack,
      output cmd_ready, done, err, mem_addr, mem_wdata, mem_re, mem_we
   );
endinterface

// File: rtl/datapath_seq_core.sv
// Single-bus datapath (regfile, HI/LO, Y, Z, MAR/MDR, ALU) with a micro-step
// sequencer that runs one register-transfer command per accepted handshake.
module datapath_seq_core #(
   parameter int WIDTH   = 32,
   parameter int NREGS   = 16,
   parameter int AW      = 9,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     clr,
   datapath_seq_core_if.slave       bus,
   output logic [WIDTH-1:0]         hi_out,
   output logic [WIDTH-1:0]         lo_out,
   input  logic [$clog2(NREGS)-1:0] dbg_sel,
   output logic [WIDTH-1:0]         dbg_data
);
   localparam int RW = $clog2(NREGS);
   localparam int SW = $clog2(WIDTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
   localparam logic [3:0] OP_SHR  = 4'd4,  OP_SHL  = 4'd5,  OP_ADDI = 4'd6,  OP_MUL  = 4'd7;
   localparam logic [3:0] OP_LD   = 4'd8,  OP_ST   = 4'd9,  OP_MFHI = 4'd10, OP_MFLO = 4'd11;
   localparam logic [3:0] OP_NEG  = 4'd12, OP_NOT  = 4'd13;

   typedef enum logic [2:0] {S_IDLE, S_TY, S_TZ, S_TWB, S_TMAR, S_TMEM, S_TLD} state_t;

   state_t             state_reg, state_next;
   logic [3:0]         op_reg;
   logic [RW-1:0]      ra_reg, rb_reg, rc_reg;
   logic [WIDTH-1:0]   imm_reg;
   logic [WIDTH-1:0]   regs [NREGS];
   logic [WIDTH-1:0]   hi_reg, lo_reg, y_reg, mdr_reg;
   logic [2*WIDTH-1:0] z_reg;
   logic [AW-1:0]      mar_reg;
   logic [TW-1:0]      tcnt_reg;
   logic               done_reg, err_reg;

   logic               accept, y_load, z_load, mar_load, mdr_ld_load, hilo_load;
   logic               wr_en, tcnt_clear, tcnt_inc, done_next, err_next;
   logic [WIDTH-1:0]   wr_data, opa, opb;
   logic [2*WIDTH-1:0] alu_out, prod;
   logic               is_mem_op, base_op;

   assign is_mem_op = (op_reg == OP_LD) || (op_reg == OP_ST);
   assign base_op   = is_mem_op || (op_reg == OP_ADDI);

   // Base-address rule: R0 reads as zero only as the base of ADDI/LD/ST.
   always_comb begin
      opa = regs[rb_reg];
      if (base_op && rb_reg == '0)
         opa = '0;
      else if (op_reg == OP_MFHI)
         opa = hi_reg;
      else if (op_reg == OP_MFLO)
         opa = lo_reg;
      opb = base_op ? imm_reg : regs[rc_reg];
   end

   // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
   assign prod = {{WIDTH{y_reg[WIDTH-1]}}, y_reg} * {{WIDTH{opb[WIDTH-1]}}, opb};

   always_comb begin
      alu_out = '0;
      case (op_reg)
         OP_ADD, OP_ADDI, OP_LD, OP_ST: alu_out[WIDTH-1:0] = y_reg + opb;
         OP_SUB:  alu_out[WIDTH-1:0] = y_reg - opb;
         OP_AND:  alu_out[WIDTH-1:0] = y_reg & opb;
         OP_OR:   alu_out[WIDTH-1:0] = y_reg | opb;
         OP_SHR:  alu_out[WIDTH-1:0] = y_reg >> opb[SW-1:0];
         OP_SHL:  alu_out[WIDTH-1:0] = y_reg << opb[SW-1:0];
         OP_MUL:  alu_out = prod;
         OP_NEG:  alu_out[WIDTH-1:0] = '0 - y_reg;
         OP_NOT:  alu_out[WIDTH-1:0] = ~y_reg;
         default: alu_out[WIDTH-1:0] = y_reg;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      accept      = 1'b0;
      y_load      = 1'b0;
      z_load      = 1'b0;
      mar_load    = 1'b0;
      mdr_ld_load = 1'b0;
      hilo_load   = 1'b0;
      wr_en       = 1'b0;
      wr_data     = z_reg[WIDTH-1:0];
      tcnt_clear  = 1'b0;
      tcnt_inc    = 1'b0;
      done_next   = 1'b0;
      err_next    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               accept = 1'b1;
               if (bus.cmd_op >= 4'd14) begin
                  done_next = 1'b1;
                  err_next  = 1'b1;
               end else begin
                  state_next = S_TY;
               end
            end
         end
         S_TY: begin
            y_load     = 1'b1;
            state_next = S_TZ;
         end
         S_TZ: begin
            z_load     = 1'b1;
            state_next = is_mem_op ? S_TMAR : S_TWB;
         end
         S_TWB: begin
            hilo_load  = (op_reg == OP_MUL);
            wr_en      = (op_reg != OP_MUL);
            done_next  = 1'b1;
            state_next = S_IDLE;
         end
         S_TMAR: begin
            mar_load   = 1'b1;
            tcnt_clear = 1'b1;
            state_next = S_TMEM;
         end
         S_TMEM: begin
            if (bus.mem_ack) begin
               if (op_reg == OP_ST) begin
                  done_next  = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  mdr_ld_load = 1'b1;
                  state_next  = S_TLD;
               end
            end else if (tcnt_reg == TW'(TIMEOUT - 1)) begin
               done_next  = 1'b1;
               err_next   = 1'b1;
               state_next = S_IDLE;
            end else begin
               tcnt_inc = 1'b1;
            end
         end
         S_TLD: begin
            wr_en      = 1'b1;
            wr_data    = mdr_reg;
            done_next  = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg <= S_IDLE;
         op_reg    <= '0;
         ra_reg    <= '0;
         rb_reg    <= '0;
         rc_reg    <= '0;
         imm_reg   <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         y_reg     <= '0;
         z_reg     <= '0;
         mar_reg   <= '0;
         mdr_reg   <= '0;
         tcnt_reg  <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
         if (accept) begin
            op_reg  <= bus.cmd_op;
            ra_reg  <= bus.cmd_ra;
            rb_reg  <= bus.cmd_rb;
            rc_reg  <= bus.cmd_rc;
            imm_reg <= bus.cmd_imm;
         end
         if (y_load)
            y_reg <= opa;
         if (z_load)
            z_reg <= alu_out;
         if (mar_load) begin
            mar_reg <= z_reg[AW-1:0];
            if (op_reg == OP_ST)
               mdr_reg <= regs[ra_reg];
         end
         if (mdr_ld_load)
            mdr_reg <= bus.mem_rdata;
         if (hilo_load)
            {hi_reg, lo_reg} <= z_reg;
         if (tcnt_clear)
            tcnt_reg <= '0;
         else if (tcnt_inc)
            tcnt_reg <= tcnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wr_en) begin
         regs[ra_reg] <= wr_data;
      end
   end

   assign bus.cmd_ready = (state_reg == S_IDLE);
   assign bus.done      = done_reg;
   assign bus.err       = err_reg;
   assign bus.mem_addr  = mar_reg;
   assign bus.mem_wdata = mdr_reg;
   assign bus.mem_re    = (state_reg == S_TMEM) && (op_reg == OP_LD);
   assign bus.mem_we    = (state_reg == S_TMEM) && (op_reg == OP_ST);
   assign hi_out        = hi_reg;
   assign lo_out        = lo_reg;
   assign dbg_data      = regs[dbg_sel];
endmodule

// File: tb/tb_datapath_seq_core.sv
// Scoreboard bench for datapath_seq_core: per-command expectations are queued
// at issue time and retired against the done pulse.
module tb_datapath_seq_core;
   localparam int WIDTH = 32, NREGS = 16, RW = 4, AW = 9, TIMEOUT = 4;
   localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
   localparam logic [3:0] OP_SHR  = 4'd4,  OP_SHL  = 4'd5,  OP_ADDI = 4'd6,  OP_MUL  = 4'd7;
   localparam logic [3:0] OP_LD   = 4'd8,  OP_ST   = 4'd9,  OP_MFHI = 4'd10, OP_MFLO = 4'd11;
   localparam logic [3:0] OP_NEG  = 4'd12, OP_NOT  = 4'd13;

   logic             clk = 1'b0;
   logic             clr;
   logic [RW-1:0]    dbg_sel;
   logic [WIDTH-1:0] dbg_data, hi_out, lo_out;

   datapath_seq_core_if #(.WIDTH(WIDTH), .RW(RW), .AW(AW)) bus ();

   datapath_seq_core #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .clr(clr), .bus(bus), .hi_out(hi_out), .lo_out(lo_out),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      int          lat;
      int          reg_idx;
      logic [31:0] val;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      int          ra, rb, rc;
      logic [31:0] imm;
      logic [31:0] val;
   } cmd_t;

   typedef struct {
      logic [3:0]  op;
      int          ra, rb;
      logic [31:0] imm, rdata;
      int          k, lat, re, we;
      logic [8:0]  addr;
      logic [31:0] data;
   } mem_t;

   exp_t        sb[$];
   exp_t        cur;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_rf [NREGS];
   int          obs_lat, obs_re, obs_we;
   logic        obs_err, obs_ready, obs_acc_ready;
   logic [8:0]  obs_addr;
   logic [31:0] obs_wdata;
   time         acc_time;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_reg(input int idx, output logic [31:0] v);
      dbg_sel = RW'(idx);
      #1;
      v = dbg_data;
   endtask

   // Issue one command, play the RAM (ack after k request cycles, k<0 = never),
   // and retire the oldest scoreboard entry when done appears or the budget runs out.
   task automatic run_cmd(input logic [3:0] op, input int ra, input int rb, input int rc,
                          input logic [31:0] imm, input int k);
      int n;
      int req;
      obs_lat = -1; obs_err = 1'bx; obs_ready = 1'bx; obs_re = 0; obs_we = 0;
      obs_addr = '0; obs_wdata = '0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_ra    = RW'(ra);
      bus.cmd_rb    = RW'(rb);
      bus.cmd_rc    = RW'(rc);
      bus.cmd_imm   = imm;
      obs_acc_ready = bus.cmd_ready;
      tick();
      acc_time = $time;
      bus.cmd_valid = 1'b0;
      n = 1;
      req = 0;
      while (n <= 60) begin
         bus.mem_ack = 1'b0;
         if (bus.mem_re || bus.mem_we) begin
            req++;
            if (bus.mem_re) obs_re++;
            else obs_we++;
            obs_addr  = bus.mem_addr;
            obs_wdata = bus.mem_wdata;
            if (k >= 0 && req == k + 1) bus.mem_ack = 1'b1;
         end
         if (bus.done) begin
            obs_lat   = n;
            obs_err   = bus.err;
            obs_ready = bus.cmd_ready;
            break;
         end
         tick();
         n++;
      end
      bus.mem_ack = 1'b0;
      cur = sb.pop_front();
      $display("txn op=%0d ra=%0d rb=%0d rc=%0d imm=%h k=%0d -> lat=%0d err=%b re=%0d we=%0d",
               op, ra, rb, rc, imm, k, obs_lat, obs_err, obs_re, obs_we);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      clr = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: ready=%b done=%b err=%b, required 1 0 0", bus.cmd_ready, bus.done, bus.err);
      end
      checks++;
      if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_mem: re=%b we=%b addr=%h wdata=%h, required all 0",
                  bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      checks++;
      if (hi_out !== '0 || lo_out !== '0) begin
         errors++;
         $display("FAIL reset_hilo: hi=%h lo=%h, required 0 0", hi_out, lo_out);
      end
      clr = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         read_reg(r, v);
         checks++;
         if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h, required 0", r, v);
         end
         exp_rf[r] = 32'h0;
      end
      tick();
   endtask

   task automatic test_alu_chain();
      cmd_t        tbl [16];
      logic [31:0] v;
      tbl = '{
         '{OP_ADDI, 1, 0, 0, 32'd5,      32'd5},
         '{OP_ADDI, 2, 0, 0, 32'hFFFFFFFD, 32'hFFFFFFFD},
         '{OP_SUB,  3, 1, 2, 32'd0,      32'd8},
         '{OP_SHL,  4, 1, 1, 32'd0,      32'hA0},
         '{OP_ADD,  7, 1, 2, 32'd0,      32'd2},
         '{OP_OR,   8, 1, 3, 32'd0,      32'hD},
         '{OP_AND,  9, 8, 1, 32'd0,      32'd5},
         '{OP_SHR, 10, 4, 1, 32'd0,      32'd5},
         '{OP_NEG, 11, 1, 0, 32'd0,      32'hFFFFFFFB},
         '{OP_NOT, 12, 1, 0, 32'd0,      32'hFFFFFFFA},
         '{OP_ADD,  0, 1, 1, 32'd0,      32'hA},
         '{OP_ADDI,13, 0, 0, 32'h22,     32'h22},
         '{OP_SHL, 13, 1,13, 32'd0,      32'h14},
         '{OP_ADD, 14, 0, 1, 32'd0,      32'hF},
         '{OP_ADDI,15, 1, 0, 32'h100,    32'h105},
         '{OP_SUB,  5, 2, 1, 32'd0,      32'hFFFFFFF8}
      };
      for (int i = 0; i < 16; i++) begin
         sb.push_back('{1'b0, 4, tbl[i].ra, tbl[i].val});
         run_cmd(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].imm, -1);
         checks++;
         if (obs_lat !== cur.lat || obs_err !== cur.err) begin
            errors++;
            $display("FAIL alu[%0d]_done: lat=%0d err=%b, required lat=%0d err=%b", i, obs_lat, obs_err, cur.lat, cur.err);
         end
         read_reg(cur.reg_idx, v);
         checks++;
         if (v !== cur.val) begin
            errors++;
            $display("FAIL alu[%0d]_R%0d: got %h, required %h", i, cur.reg_idx, v, cur.val);
         end
         exp_rf[tbl[i].ra] = tbl[i].val;
      end
   endtask

   task automatic test_mul();
      logic [31:0] v;
      sb.push_back('{1'b0, 4, 1, 32'hFFFFFFFE});
      run_cmd(OP_ADDI, 1, 0, 0, 32'hFFFFFFFE, -1);
      exp_rf[1] = 32'hFFFFFFFE;
      sb.push_back('{1'b0, 4, 2, 32'd3});
      run_cmd(OP_ADDI, 2, 0, 0, 32'd3, -1);
      exp_rf[2] = 32'd3;
      sb.push_back('{1'b0, 4, -1, 32'h0});
      run_cmd(OP_MUL, 5, 1, 2, 32'd0, -1);
      checks++;
      if (obs_lat !== cur.lat || obs_err !== cur.err) begin
         errors++;
         $display("FAIL mul_done: lat=%0d err=%b, required lat=%0d err=%b", obs_lat, obs_err, cur.lat, cur.err);
      end
      checks++;
      if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFA) begin
         errors++;
         $display("FAIL mul_hilo: hi=%h lo=%h, required FFFFFFFF FFFFFFFA", hi_out, lo_out);
      end
      for (int r = 0; r < NREGS; r++) begin
         read_reg(r, v);
         checks++;
         if (v !== exp_rf[r]) begin
            errors++;
            $display("FAIL mul_keep_R%0d: got %h, required %h", r, v, exp_rf[r]);
         end
      end
      tick();
      sb.push_back('{1'b0, 4, 5, 32'hFFFFFFFA});
      run_cmd(OP_MFLO, 5, 0, 0, 32'd0, -1);
      read_reg(cur.reg_idx, v);
      checks++;
      if (obs_lat !== cur.lat || v !== cur.val) begin
         errors++;
         $display("FAIL mflo: lat=%0d R5=%h, required lat=%0d R5=%h", obs_lat, v, cur.lat, cur.val);
      end
      exp_rf[5] = 32'hFFFFFFFA;
      sb.push_back('{1'b0, 4, 6, 32'hFFFFFFFF});
      run_cmd(OP_MFHI, 6, 0, 0, 32'd0, -1);
      read_reg(cur.reg_idx, v);
      checks++;
      if (obs_lat !== cur.lat || v !== cur.val) begin
         errors++;
         $display("FAIL mfhi: lat=%0d R6=%h, required lat=%0d R6=%h", obs_lat, v, cur.lat, cur.val);
      end
      exp_rf[6] = 32'hFFFFFFFF;
      sb.push_back('{1'b0, 4, 0, 32'hA});
      run_cmd(OP_MUL, 0, 14, 15, 32'd0, -1);
      read_reg(cur.reg_idx, v);
      checks++;
      if (hi_out !== 32'h0 || lo_out !== 32'hF4B || v !== cur.val) begin
         errors++;
         $display("FAIL mul_pos: hi=%h lo=%h R0=%h, required 0 F4B %h", hi_out, lo_out, v, cur.val);
      end
   endtask

   task automatic test_memory();
      mem_t        tbl [4];
      logic [31:0] v;
      tbl = '{
         '{OP_ST, 1, 0, 32'h10,  32'h0,        2, 7, 0, 3, 9'h010, 32'hFFFFFFFE},
         '{OP_LD, 6, 0, 32'h10,  32'h1234,     0, 6, 1, 0, 9'h010, 32'h1234},
         '{OP_LD, 7, 2, 32'h20,  32'hCAFEF00D, 1, 7, 2, 0, 9'h023, 32'hCAFEF00D},
         '{OP_ST, 2, 2, 32'h1FF, 32'h0,        0, 5, 0, 1, 9'h002, 32'd3}
      };
      for (int i = 0; i < 4; i++) begin
         bus.mem_rdata = tbl[i].rdata;
         sb.push_back('{1'b0, tbl[i].lat, (tbl[i].op == OP_LD) ? tbl[i].ra : -1, tbl[i].data});
         run_cmd(tbl[i].op, tbl[i].ra, tbl[i].rb, 0, tbl[i].imm, tbl[i].k);
         checks++;
         if (obs_lat !== cur.lat || obs_err !== cur.err) begin
            errors++;
            $display("FAIL mem[%0d]_done: lat=%0d err=%b, required lat=%0d err=%b", i, obs_lat, obs_err, cur.lat, cur.err);
         end
         checks++;
         if (obs_re !== tbl[i].re || obs_we !== tbl[i].we || obs_addr !== tbl[i].addr) begin
            errors++;
            $display("FAIL mem[%0d]_req: re=%0d we=%0d addr=%h, required re=%0d we=%0d addr=%h",
                     i, obs_re, obs_we, obs_addr, tbl[i].re, tbl[i].we, tbl[i].addr);
         end
         checks++;
         if (tbl[i].op == OP_ST) begin
            if (obs_wdata !== cur.val) begin
               errors++;
               $display("FAIL mem[%0d]_wdata: got %h, required %h", i, obs_wdata, cur.val);
            end
         end else begin
            read_reg(cur.reg_idx, v);
            if (v !== cur.val) begin
               errors++;
               $display("FAIL mem[%0d]_R%0d: got %h, required %h", i, cur.reg_idx, v, cur.val);
            end
            exp_rf[tbl[i].ra] = tbl[i].data;
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] v;
      bus.mem_rdata = 32'hDEADBEEF;
      sb.push_back('{1'b1, 8, 6, 32'h1234});
      run_cmd(OP_LD, 6, 0, 0, 32'h30, -1);
      read_reg(cur.reg_idx, v);
      checks++;
      if (obs_lat !== cur.lat || obs_err !== cur.err || obs_re !== TIMEOUT) begin
         errors++;
         $display("FAIL ld_timeout: lat=%0d err=%b re=%0d, required lat=%0d err=%b re=%0d",
                  obs_lat, obs_err, obs_re, cur.lat, cur.err, TIMEOUT);
      end
      checks++;
      if (v !== cur.val) begin
         errors++;
         $display("FAIL ld_timeout_R6: got %h, required %h", v, cur.val);
      end
      sb.push_back('{1'b1, 8, -1, 32'h0});
      run_cmd(OP_ST, 1, 0, 0, 32'h44, -1);
      checks++;
      if (obs_lat !== cur.lat || obs_err !== cur.err || obs_we !== TIMEOUT) begin
         errors++;
         $display("FAIL st_timeout: lat=%0d err=%b we=%0d, required lat=%0d err=%b we=%0d",
                  obs_lat, obs_err, obs_we, cur.lat, cur.err, TIMEOUT);
      end
      for (int op = 14; op <= 15; op++) begin
         sb.push_back('{1'b1, 1, -1, 32'h0});
         run_cmd(4'(op), 3, 1, 2, 32'd0, -1);
         checks++;
         if (obs_lat !== cur.lat || obs_err !== cur.err || obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op%0d: lat=%0d err=%b ready=%b, required lat=%0d err=%b ready=1",
                     op, obs_lat, obs_err, obs_ready, cur.lat, cur.err);
         end
      end
      read_reg(3, v);
      checks++;
      if (v !== exp_rf[3]) begin
         errors++;
         $display("FAIL illegal_keep_R3: got %h, required %h", v, exp_rf[3]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      time         prev;
      cmd_t        tbl [3];
      tbl = '{
         '{OP_ADDI, 1, 0, 0, 32'h11, 32'h11},
         '{OP_ADDI, 2, 0, 0, 32'h22, 32'h22},
         '{OP_ADDI, 3, 1, 0, 32'h3,  32'h14}
      };
      prev = 0;
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{1'b0, 4, tbl[i].ra, tbl[i].val});
         run_cmd(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].imm, -1);
         read_reg(cur.reg_idx, v);
         checks++;
         if (obs_lat !== cur.lat || obs_ready !== 1'b1 || v !== cur.val) begin
            errors++;
            $display("FAIL b2b[%0d]: lat=%0d ready=%b R%0d=%h, required lat=%0d ready=1 val=%h",
                     i, obs_lat, obs_ready, cur.reg_idx, v, cur.lat, cur.val);
         end
         if (i > 0) begin
            checks++;
            if (acc_time - prev != 40) begin
               errors++;
               $display("FAIL b2b[%0d]_spacing: got %0t, required 40", i, acc_time - prev);
            end
         end
         prev = acc_time;
         exp_rf[tbl[i].ra] = tbl[i].val;
      end
   endtask

   task automatic test_clr_abort();
      logic [31:0] v;
      tick();
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_ST;
      bus.cmd_ra    = RW'(1);
      bus.cmd_rb    = RW'(0);
      bus.cmd_imm   = 32'h40;
      tick();
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 9'h040) begin
         errors++;
         $display("FAIL clr_pre: we=%b addr=%h, required 1 040", bus.mem_we, bus.mem_addr);
      end
      clr = 1'b1;
      tick();
      checks++;
      if (bus.mem_we !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL clr_abort: we=%b done=%b ready=%b, required 0 0 1", bus.mem_we, bus.done, bus.cmd_ready);
      end
      for (int r = 0; r < NREGS; r++) begin
         read_reg(r, v);
         checks++;
         if (v !== 32'h0) begin
            errors++;
            $display("FAIL clr_R%0d: got %h, required 0", r, v);
         end
         exp_rf[r] = 32'h0;
      end
      tick();
      clr = 1'b0;
      sb.push_back('{1'b0, 4, 3, 32'd7});
      run_cmd(OP_ADDI, 3, 0, 0, 32'd7, -1);
      read_reg(cur.reg_idx, v);
      checks++;
      if (obs_acc_ready !== 1'b1 || obs_lat !== cur.lat || v !== cur.val) begin
         errors++;
         $display("FAIL clr_resume: ready=%b lat=%0d R3=%h, required 1 %0d %h",
                  obs_acc_ready, obs_lat, v, cur.lat, cur.val);
      end
      exp_rf[3] = 32'd7;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clr           = 1'b1;
      dbg_sel       = '0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_ra    = '0;
      bus.cmd_rb    = '0;
      bus.cmd_rc    = '0;
      bus.cmd_imm   = '0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;
      test_reset();
      test_alu_chain();
      test_mul();
      test_memory();
      test_timeout();
      test_back_to_back();
      test_clr_abort();
      test_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
